// File: rtl/trg_axis_if.sv
// ADC AXI-Stream tap between the RF data converter and the trigger sequencer.
interface trg_axis_if #(
    parameter int unsigned TDATA_WIDTH = 128
);
    logic [TDATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                   S_AXIS_TVALID;
    logic                   S_AXIS_TREADY;

    modport master (output S_AXIS_TDATA, output S_AXIS_TVALID, input  S_AXIS_TREADY);
    modport slave  (input  S_AXIS_TDATA, input  S_AXIS_TVALID, output S_AXIS_TREADY);
endinterface

// File: rtl/trg_ctrl.sv
// Trigger sequencer: threshold detect on ADC lanes, acquisition window control.
// Optional feature macro: TRG_HYSTERESIS_EN (release at THRESHOLD-HYSTERESIS).
module trg_ctrl #(
    parameter int THRESHOLD            = 410,
    parameter int HYSTERESIS           = 32,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int PRE_ACQUI_LEN        = 12,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int ACQUI_LEN            = 100,
    parameter int HOLDOFF_LEN          = 4
) (
    input  logic                        AXIS_ACLK,
    input  logic                        AXIS_ARESET,
    trg_axis_if.slave                   s_axis,
    input  logic                        FIFO_FULL,
    output logic                        START_TRG,
    output logic                        FINALIZE_TRG,
    output logic [TIME_STAMP_WIDTH-1:0] TIME_STAMP,
    output logic                        TRG_BUSY,
    output logic [15:0]                 DROP_CNT
);
    localparam int unsigned LANES = S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned CW    = ADC_RESOLUTION_WIDTH + 1;
    localparam int unsigned TSW   = TIME_STAMP_WIDTH;
    localparam int unsigned FW    = $clog2(PRE_ACQUI_LEN + 1);
    localparam int unsigned BW    = $clog2(ACQUI_LEN + 1);
    localparam int unsigned PW    = $clog2(POST_ACQUI_LEN + 1);
    localparam int unsigned HW    = $clog2(HOLDOFF_LEN + 1);

    localparam logic signed [CW-1:0] THR_X = CW'(THRESHOLD);
`ifdef TRG_HYSTERESIS_EN
    localparam logic signed [CW-1:0] REL_X = CW'(THRESHOLD - HYSTERESIS);
`else
    localparam logic signed [CW-1:0] REL_X = CW'(THRESHOLD);
`endif

    typedef enum logic [2:0] {S_FILL, S_IDLE, S_ACQ, S_POST, S_HOLD} state_t;

    state_t r_state, w_state_nxt;
    logic [FW-1:0]  r_fill, w_fill_nxt, w_fill_inc;
    logic [BW-1:0]  r_beat, w_beat_nxt, w_beat_inc;
    logic [PW-1:0]  r_post, w_post_nxt, w_post_inc;
    logic [HW-1:0]  r_hold, w_hold_nxt, w_hold_inc;
    logic [TSW-1:0] r_ts, r_tstamp, w_tstamp_nxt;
    logic [15:0]    r_drop, w_drop_nxt;
    logic           r_start, w_start_nxt, r_fin, w_fin_nxt, r_busy, w_busy_nxt, r_tready;

    logic                                   w_hit, w_above_rel, w_low, w_valid;
    logic signed [ADC_RESOLUTION_WIDTH-1:0] w_lane;
    logic signed [CW-1:0]                   w_ext;
    logic                                   w_unused;

    assign w_valid    = s_axis.S_AXIS_TVALID;
    assign w_fill_inc = r_fill + FW'(1);
    assign w_beat_inc = r_beat + BW'(1);
    assign w_post_inc = r_post + PW'(1);
    assign w_hold_inc = r_hold + HW'(1);
    assign w_unused   = ^{1'b0, s_axis.S_AXIS_TDATA, 32'(HYSTERESIS)};

    // Lane decode: MSB-aligned signed samples, compared one bit wider so REL cannot wrap
    always_comb begin
        w_hit       = 1'b0;
        w_above_rel = 1'b0;
        w_lane      = '0;
        w_ext       = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            w_lane = s_axis.S_AXIS_TDATA[k*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 -: ADC_RESOLUTION_WIDTH];
            w_ext  = CW'(w_lane);
            if (w_ext > THR_X) w_hit       = 1'b1;
            if (w_ext > REL_X) w_above_rel = 1'b1;
        end
    end
    assign w_low = ~w_above_rel;

    // State and datapath registers
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_state  <= S_FILL;
            r_fill   <= '0;
            r_beat   <= '0;
            r_post   <= '0;
            r_hold   <= '0;
            r_ts     <= '0;
            r_tstamp <= '0;
            r_drop   <= '0;
            r_start  <= 1'b0;
            r_fin    <= 1'b0;
            r_busy   <= 1'b1;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_beat   <= w_beat_nxt;
            r_post   <= w_post_nxt;
            r_hold   <= w_hold_nxt;
            r_ts     <= r_ts + TSW'(1);
            r_tstamp <= w_tstamp_nxt;
            r_drop   <= w_drop_nxt;
            r_start  <= w_start_nxt;
            r_fin    <= w_fin_nxt;
            r_busy   <= w_busy_nxt;
            r_tready <= 1'b1;
        end
    end

    // Next-state logic; limit and FIFO-full exits outrank signal release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: if (w_valid && (w_fill_inc == FW'(PRE_ACQUI_LEN))) w_state_nxt = S_IDLE;
            S_IDLE: if (w_valid && w_hit && !FIFO_FULL) w_state_nxt = S_ACQ;
            S_ACQ: begin
                if (w_valid) begin
                    if ((w_beat_inc == BW'(ACQUI_LEN)) || FIFO_FULL) w_state_nxt = S_HOLD;
                    else if (w_low)                                  w_state_nxt = S_POST;
                end
            end
            S_POST: begin
                if (w_valid && ((w_post_inc == PW'(POST_ACQUI_LEN)) ||
                                (w_beat_inc == BW'(ACQUI_LEN)) || FIFO_FULL))
                    w_state_nxt = S_HOLD;
            end
            S_HOLD: if (w_hold_inc == HW'(HOLDOFF_LEN)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Output and counter next values
    always_comb begin
        w_fill_nxt   = r_fill;
        w_beat_nxt   = r_beat;
        w_post_nxt   = r_post;
        w_hold_nxt   = '0;
        w_tstamp_nxt = r_tstamp;
        w_drop_nxt   = r_drop;
        w_fin_nxt    = 1'b0;
        w_start_nxt  = (w_state_nxt == S_ACQ) || (w_state_nxt == S_POST);
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (r_state)
            S_FILL: if (w_valid) w_fill_nxt = w_fill_inc;
            S_IDLE: begin
                if (w_valid && w_hit) begin
                    if (FIFO_FULL) begin
                        if (r_drop != 16'hFFFF) w_drop_nxt = r_drop + 16'd1;
                    end else begin
                        w_tstamp_nxt = r_ts;
                        w_beat_nxt   = BW'(1);
                    end
                end
            end
            S_ACQ: begin
                if (w_valid) begin
                    w_beat_nxt = w_beat_inc;
                    w_post_nxt = '0;
                    w_fin_nxt  = (w_state_nxt != S_ACQ);
                end
            end
            S_POST: begin
                if (w_valid) begin
                    w_beat_nxt = w_beat_inc;
                    w_post_nxt = w_post_inc;
                end
            end
            S_HOLD:  w_hold_nxt = w_hold_inc;
            default: ;
        endcase
    end

    assign START_TRG            = r_start;
    assign FINALIZE_TRG         = r_fin;
    assign TIME_STAMP           = r_tstamp;
    assign TRG_BUSY             = r_busy;
    assign DROP_CNT             = r_drop;
    assign s_axis.S_AXIS_TREADY = r_tready;
endmodule

// File: tb/tb_trg_ctrl.sv
// Directed self-checking bench for trg_ctrl (default build and TRG_HYSTERESIS_EN build).
module tb_trg_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        full;
    logic        start_trg, fin_trg, busy;
    logic [15:0] tstamp, drop;
    int          n_tests = 0;
    int          n_fail  = 0;

    trg_axis_if #(.TDATA_WIDTH(128)) axis_if ();

    trg_ctrl dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESET  (rst),
        .s_axis       (axis_if),
        .FIFO_FULL    (full),
        .START_TRG    (start_trg),
        .FINALIZE_TRG (fin_trg),
        .TIME_STAMP   (tstamp),
        .TRG_BUSY     (busy),
        .DROP_CNT     (drop)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lane(input int k, input int v);
        logic [127:0] d;
        d = '0;
        d[k*16 +: 16] = 16'(v << 4);
        return d;
    endfunction

    task automatic beat(input logic [127:0] d, input logic v);
        axis_if.S_AXIS_TDATA  = d;
        axis_if.S_AXIS_TVALID = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        axis_if.S_AXIS_TDATA  = '0;
        axis_if.S_AXIS_TVALID = 1'b0;
        full = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start",  32'(start_trg), 0);
        chk("rst_fin",    32'(fin_trg),   0);
        chk("rst_ts",     32'(tstamp),    0);
        chk("rst_busy",   32'(busy),      1);
        chk("rst_drop",   32'(drop),      0);
        chk("rst_tready", 32'(axis_if.S_AXIS_TREADY), 0);
        rst = 1'b0;

        repeat (11) beat('0, 1'b1);
        chk("fill_busy",  32'(busy), 1);
        chk("tready_on",  32'(axis_if.S_AXIS_TREADY), 1);
        beat('0, 1'b1);
        chk("fill_done_idle", 32'(busy), 0);

        beat(lane(3, 500), 1'b0);
        chk("novalid_no_trig", 32'(start_trg), 0);
        beat(lane(3, 500), 1'b1);
        chk("trig_start", 32'(start_trg), 1);
        chk("trig_ts",    32'(tstamp),    13);
        chk("trig_busy",  32'(busy),      1);

        repeat (5) beat(lane(3, 500), 1'b1);
        chk("acq_start", 32'(start_trg), 1);
        chk("acq_nofin", 32'(fin_trg),   0);
        beat('0, 1'b1);
        chk("rel_fin",   32'(fin_trg),   1);
        chk("rel_start", 32'(start_trg), 1);
        beat('0, 1'b1);
        chk("fin_one_cycle", 32'(fin_trg), 0);
        repeat (36) beat('0, 1'b1);
        chk("post_start", 32'(start_trg), 1);
        chk("ts_held",    32'(tstamp),    13);
        beat('0, 1'b1);
        chk("post_end_start", 32'(start_trg), 0);
        chk("post_end_busy",  32'(busy),      1);
        chk("post_end_nofin", 32'(fin_trg),   0);

        repeat (4) beat(lane(3, 500), 1'b1);
        chk("holdoff_no_trig", 32'(start_trg), 0);
        chk("holdoff_to_idle", 32'(busy),      0);
        beat(lane(3, 500), 1'b1);
        chk("trig2_start", 32'(start_trg), 1);
        chk("trig2_ts",    32'(tstamp),    62);
        repeat (98) beat(lane(3, 500), 1'b1);
        chk("maxlen_99_start", 32'(start_trg), 1);
        chk("maxlen_99_nofin", 32'(fin_trg),   0);
        beat(lane(3, 500), 1'b1);
        chk("maxlen_fin",   32'(fin_trg),   1);
        chk("maxlen_start", 32'(start_trg), 0);
        beat('0, 1'b0);
        chk("maxlen_fin_clr", 32'(fin_trg), 0);
        repeat (3) beat('0, 1'b0);
        chk("holdoff_idle_novalid", 32'(busy), 0);

        full = 1'b1;
        beat(lane(5, 500), 1'b1);
        chk("drop_1", 32'(drop), 1);
        beat('0, 1'b1);
        beat(lane(0, 1000), 1'b1);
        beat('0, 1'b1);
        beat(lane(7, 411), 1'b1);
        chk("drop_3",       32'(drop),      3);
        chk("drop_nostart", 32'(start_trg), 0);
        full = 1'b0;

        beat(lane(0, -500), 1'b1);
        chk("neg_no_trig", 32'(start_trg), 0);
        beat(lane(1, 410), 1'b1);
        chk("eq_thr_no_trig", 32'(start_trg), 0);
        beat(lane(1, 411), 1'b1);
        chk("thr_plus1_trig", 32'(start_trg), 1);
        full = 1'b1;
        beat(lane(1, 500), 1'b1);
        chk("full_acq_fin",   32'(fin_trg),   1);
        chk("full_acq_start", 32'(start_trg), 0);
        full = 1'b0;
        repeat (4) beat('0, 1'b0);

        beat(lane(3, 500), 1'b1);
        beat(lane(2, 400), 1'b1);
`ifdef TRG_HYSTERESIS_EN
        chk("hyst_400_nofin", 32'(fin_trg),   0);
        chk("hyst_400_start", 32'(start_trg), 1);
        beat(lane(2, 370), 1'b1);
        chk("hyst_370_fin",   32'(fin_trg),   1);
`else
        chk("nohyst_400_fin",   32'(fin_trg),   1);
        chk("nohyst_400_start", 32'(start_trg), 1);
`endif
        full = 1'b1;
        beat('0, 1'b1);
        full = 1'b0;
        chk("full_post_start", 32'(start_trg), 0);
        chk("full_post_nofin", 32'(fin_trg),   0);
        repeat (4) beat('0, 1'b0);

        beat(lane(3, 500), 1'b1);
        repeat (2) beat(lane(3, 500), 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_start",  32'(start_trg), 0);
        chk("midrst_fin",    32'(fin_trg),   0);
        chk("midrst_ts",     32'(tstamp),    0);
        chk("midrst_busy",   32'(busy),      1);
        chk("midrst_drop",   32'(drop),      0);
        chk("midrst_tready", 32'(axis_if.S_AXIS_TREADY), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("postrst_nofin", 32'(fin_trg), 0);
        repeat (11) beat(lane(3, 500), 1'b1);
        chk("refill_ignores_hit", 32'(start_trg), 0);
        beat(lane(3, 500), 1'b1);
        chk("refill_12_nostart", 32'(start_trg), 0);
        chk("refill_12_idle",    32'(busy),      0);
        beat(lane(3, 500), 1'b1);
        chk("refill_trig", 32'(start_trg), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
